exe_lane_allocator: RTL

Parametrised, load-aware execution-lane allocator for the dispatch stage. It assigns each instruction in a dispatch bundle to an execution lane, based on instruction class, the active-lane mask and per-lane occupancy credits. Occupancy counters track dispatched-but-not-issued instructions per lane. In load-balanced mode new work goes to the least-occupied eligible lane; in round-robin mode it rotates. The block sits between rename/dispatch and the issue queue. It raises a bundle-wide stall when any instruction cannot be placed.

---
 rtl/exe_lane_allocator.sv | 119 +++++++++++
 1 files changed

// File: rtl/exe_lane_allocator.sv
// exe_lane_allocator: assigns dispatch-bundle slots to execution lanes by class,
// lane mask and occupancy credit; load-balanced or round-robin selection.
module exe_lane_allocator #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int NUM_LANES = 6,
    parameter int LANE_LOG = 3,
    parameter int CREDIT_MAX = 8,
    parameter logic [NUM_LANES-1:0] SIMPLE_MASK = 6'b111100,
    parameter logic [NUM_LANES-1:0] COMPLEX_MASK = 6'b001100,
    localparam int CW = $clog2(CREDIT_MAX + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               recoverFlag_i,
    input  logic                               backEndReady_i,
    input  logic                               rrMode_i,
    input  logic [NUM_LANES-1:0]               laneActive_i,
    input  logic [NUM_LANES-1:0]               laneIssue_i,
    input  logic [DISPATCH_WIDTH-1:0]          instValid_i,
    input  logic [DISPATCH_WIDTH*3-1:0]        instType_i,
    output logic [DISPATCH_WIDTH*LANE_LOG-1:0] exeLane_o,
    output logic [DISPATCH_WIDTH-1:0]          isSimple_o,
    output logic [DISPATCH_WIDTH-1:0]          isFP_o,
    output logic                               stall_o,
    output logic [NUM_LANES*CW-1:0]            laneCount_o
);
    localparam logic [NUM_LANES-1:0] MEM_MASK = NUM_LANES'(1);
    localparam logic [NUM_LANES-1:0] CTRL_MASK = NUM_LANES'(2);

    logic [CW-1:0] count [NUM_LANES];
    logic [CW-1:0] tCount [NUM_LANES];
    logic [CW-1:0] nextCount [NUM_LANES];
    logic [LANE_LOG-1:0] ptrS, ptrC, tPtrS, tPtrC, ptr, best, nxt;
    logic [NUM_LANES-1:0] elig;
    logic [CW-1:0] bestCnt;
    logic [2:0] ty;
    logic found, stall, fire;
    int lane;

    // Slots are resolved in order; each sees the tentative counts/pointers of earlier slots.
    always_comb begin
        tCount = count;
        tPtrS = ptrS;
        tPtrC = ptrC;
        stall = 1'b0;
        exeLane_o = '0;
        isSimple_o = '0;
        isFP_o = '0;
        ty = '0;
        ptr = '0;
        elig = '0;
        found = 1'b0;
        best = '0;
        bestCnt = '0;
        nxt = '0;
        lane = 0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            ty = instType_i[i*3 +: 3];
            ptr = (ty == 3'd3) ? tPtrC : tPtrS;
            elig = (ty == 3'd0) ? MEM_MASK :
                   (ty == 3'd1) ? CTRL_MASK :
                   (ty == 3'd2 || ty == 3'd4) ? (SIMPLE_MASK & laneActive_i) :
                   (ty == 3'd3) ? (COMPLEX_MASK & laneActive_i) : '0;
            found = 1'b0;
            best = '0;
            bestCnt = '0;
            // Circular scan from the class pointer gives the tie-break order for free.
            for (int k = 0; k < NUM_LANES; k++) begin
                lane = int'(ptr) + k;
                if (lane >= NUM_LANES) lane = lane - NUM_LANES;
                if (elig[lane] && tCount[lane] != CW'(CREDIT_MAX) &&
                    (!found || (!rrMode_i && tCount[lane] < bestCnt))) begin
                    found = 1'b1;
                    best = LANE_LOG'(lane);
                    bestCnt = tCount[lane];
                end
            end
            if (instValid_i[i] && ty <= 3'd4) begin
                if (found) begin
                    tCount[best] = tCount[best] + 1'b1;
                    exeLane_o[i*LANE_LOG +: LANE_LOG] = best;
                    isSimple_o[i] = (ty == 3'd2) || (ty == 3'd4);
                    isFP_o[i] = (ty == 3'd4);
                    nxt = (best == LANE_LOG'(NUM_LANES - 1)) ? '0 : best + 1'b1;
                    if (ty == 3'd3) tPtrC = nxt;
                    else if (ty == 3'd2 || ty == 3'd4) tPtrS = nxt;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign stall_o = stall;
    assign fire = backEndReady_i & ~stall & ~recoverFlag_i;

    always_comb begin
        laneCount_o = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            nextCount[l] = fire ? tCount[l] : count[l];
            if (laneIssue_i[l] && nextCount[l] != '0) nextCount[l] = nextCount[l] - 1'b1;
            laneCount_o[l*CW +: CW] = count[l];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || recoverFlag_i) begin
            for (int l = 0; l < NUM_LANES; l++) count[l] <= '0;
            ptrS <= '0;
            ptrC <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) count[l] <= nextCount[l];
            if (fire) begin
                ptrS <= tPtrS;
                ptrC <= tPtrC;
            end
        end
    end
endmodule
